// File: rtl/vga_sig_pkg.sv
// Shared types and the CRC-16-CCITT helper for the VGA frame-signature block.
// The helper folds one 12-bit pixel per call.
package vga_sig_pkg;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Non-reflected, MSB first: data12[11] enters the register first.
  function automatic logic [15:0] crc16_step12(input logic [15:0] crc, input logic [11:0] data12);
    logic [15:0] c;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ data12[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                   c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel-stream bundle passed between VGA draw stages.
// The stream has no valid/ready: every clock carries one pixel slot and no sink may stall it.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_sig_checker.sv
// Cycle-by-cycle consistency check of registered hcount/vcount/blanking.
// err is a combinational strobe for the current registered sample.
module vga_sig_checker #(
  parameter int HACTIVE = 1024,
  parameter int VACTIVE = 768,
  parameter int HTOTAL  = 1344,
  parameter int VTOTAL  = 806
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_i,
  input  logic [10:0] vcount_i,
  input  logic        hblnk_i,
  input  logic        vblnk_i,
  output logic        err_o
);

  logic [10:0] prev_hc_q;
  logic [10:0] prev_vc_q;
  logic [10:0] exp_hc;
  logic [10:0] exp_vc;
  logic        h_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_hc_q <= '0;
      prev_vc_q <= '0;
    end else begin
      prev_hc_q <= hcount_i;
      prev_vc_q <= vcount_i;
    end
  end

  always_comb begin
    h_wrap = (prev_hc_q == 11'(HTOTAL - 1));
    exp_hc = h_wrap ? 11'd0 : prev_hc_q + 11'd1;
    exp_vc = prev_vc_q;
    if (h_wrap) exp_vc = (prev_vc_q == 11'(VTOTAL - 1)) ? 11'd0 : prev_vc_q + 11'd1;
    // Unknown counters must never pass as a clean frame.
    err_o = (hcount_i != exp_hc) || (vcount_i != exp_vc) ||
            (hblnk_i != (hcount_i >= 11'(HACTIVE))) ||
            (vblnk_i != (vcount_i >= 11'(VACTIVE))) ||
            $isunknown({hcount_i, vcount_i});
  end

endmodule

// File: rtl/vga_frame_signature.sv
// Observes a vga_if stream, checks its timing and reports a CRC-16 of each frame's active pixels.
// Optional macro VGA_FRAME_SIG_STICKY_ERR_EN keeps timing_err set until reset.
module vga_frame_signature
  import vga_sig_pkg::*;
#(
  parameter int HACTIVE = 1024,
  parameter int VACTIVE = 768,
  parameter int HTOTAL  = 1344,
  parameter int VTOTAL  = 806
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           in,
  output logic [15:0] signature,
  output logic        sig_valid,
  output logic [15:0] frame_cnt,
  output logic        locked,
  output logic        timing_err,
  output state_t      state
);

  localparam logic [19:0] PIX_TOTAL = 20'(HACTIVE * VACTIVE);

  logic [10:0] hc_q, vc_q;
  logic        vs_q, vs_prev_q, hb_q, vb_q;
  logic [11:0] rgb_q;

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d, signature_q, signature_d, frame_cnt_q, frame_cnt_d;
  logic [19:0] pix_q, pix_d;
  logic        err_q, err_d, locked_q, locked_d, timing_err_q, timing_err_d;

  logic        boundary, active, chk_err, acc_err, frame_err;
  logic [15:0] acc_crc;
  logic [19:0] acc_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q <= '0; vc_q <= '0; vs_q <= 1'b0; vs_prev_q <= 1'b0;
      hb_q <= 1'b0; vb_q <= 1'b0; rgb_q <= '0;
      state_q <= SEEK; crc_q <= '0; pix_q <= '0; err_q <= 1'b0;
      locked_q <= 1'b0; signature_q <= '0; frame_cnt_q <= '0; timing_err_q <= 1'b0;
    end else begin
      hc_q <= in.hcount; vc_q <= in.vcount; vs_q <= in.vsync; vs_prev_q <= vs_q;
      hb_q <= in.hblnk; vb_q <= in.vblnk; rgb_q <= in.rgb;
      state_q <= state_d; crc_q <= crc_d; pix_q <= pix_d; err_q <= err_d;
      locked_q <= locked_d; signature_q <= signature_d; frame_cnt_q <= frame_cnt_d;
      timing_err_q <= timing_err_d;
    end
  end

  vga_sig_checker #(
    .HACTIVE(HACTIVE), .VACTIVE(VACTIVE), .HTOTAL(HTOTAL), .VTOTAL(VTOTAL)
  ) u_checker (
    .clk(clk), .rst(rst), .hcount_i(hc_q), .vcount_i(vc_q),
    .hblnk_i(hb_q), .vblnk_i(vb_q), .err_o(chk_err)
  );

  assign boundary = vs_q & ~vs_prev_q;
  assign active   = ~hb_q & ~vb_q;

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    pix_d        = pix_q;
    err_d        = err_q;
    locked_d     = locked_q;
    signature_d  = signature_q;
    frame_cnt_d  = frame_cnt_q;
    timing_err_d = timing_err_q;
    // This cycle's contribution is folded before closing, so a boundary-cycle
    // failure lands in the frame being reported.
    acc_crc   = active ? crc16_step12(crc_q, rgb_q) : crc_q;
    acc_pix   = active ? pix_q + 20'd1 : pix_q;
    acc_err   = err_q | chk_err;
    frame_err = acc_err | (acc_pix != PIX_TOTAL);
    case (state_q)
      SEEK: begin
        if (boundary) begin
          state_d  = ACCUM;
          locked_d = 1'b1;
          crc_d    = CRC_INIT;
          pix_d    = '0;
          err_d    = 1'b0;
        end
      end
      ACCUM: begin
        crc_d = acc_crc;
        pix_d = acc_pix;
        err_d = acc_err;
        if (boundary) begin
          state_d     = REPORT;
          signature_d = acc_crc;
          frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef VGA_FRAME_SIG_STICKY_ERR_EN
          timing_err_d = frame_err | timing_err_q;
`else
          timing_err_d = frame_err;
`endif
        end
      end
      REPORT: begin
        state_d = ACCUM;
        crc_d   = CRC_INIT;
        pix_d   = '0;
        err_d   = chk_err;
      end
      default: state_d = SEEK;
    endcase
  end

  assign signature  = signature_q;
  assign sig_valid  = (state_q == REPORT);
  assign frame_cnt  = frame_cnt_q;
  assign locked     = locked_q;
  assign timing_err = timing_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_vga_frame_signature.sv
// Directed bench for vga_frame_signature at a reduced 4x2 active / 6x4 total raster.
// The expected CRC comes from an augmented-message polynomial division, independent of the per-pixel fold.
module tb_vga_frame_signature;
  import vga_sig_pkg::*;

  localparam int HA = 4;
  localparam int VA = 2;
  localparam int HT = 6;
  localparam int VT = 4;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] signature;
  logic        sig_valid;
  logic [15:0] frame_cnt;
  logic        locked;
  logic        timing_err;
  state_t      state;

  vga_if vif();

  vga_frame_signature #(.HACTIVE(HA), .VACTIVE(VA), .HTOTAL(HT), .VTOTAL(VT)) dut (
    .clk(clk), .rst(rst), .in(vif), .signature(signature), .sig_valid(sig_valid),
    .frame_cnt(frame_cnt), .locked(locked), .timing_err(timing_err), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int vs_cyc = 0;

  logic [11:0] frame_pix[$];
  logic [15:0] exp_q[$];

  int          mon_pulses = 0;
  logic [15:0] mon_sig = '0;
  logic [15:0] mon_cnt = '0;
  logic        mon_err = 1'b0;
  int          mon_cyc = 0;

`ifdef VGA_FRAME_SIG_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sig_valid === 1'b1) begin
      mon_pulses++;
      mon_sig = signature;
      mon_cnt = frame_cnt;
      mon_err = timing_err;
      mon_cyc = cyc;
    end
  end

  // CRC = (M * x^16 + INIT * x^len(M)) mod P, by long division over the bit stream.
  function automatic logic [15:0] model_crc(input logic [11:0] pix[$]);
    bit          m[$];
    logic [16:0] gp;
    logic [15:0] init;
    logic [15:0] r;
    int          len;
    gp   = 17'h11021;
    init = 16'hFFFF;
    foreach (pix[p]) for (int i = 11; i >= 0; i--) m.push_back(pix[p][i]);
    len = m.size();
    for (int i = 0; i < 16; i++) m[i] = m[i] ^ init[15 - i];
    for (int i = 0; i < 16; i++) m.push_back(1'b0);
    for (int i = 0; i < len; i++)
      if (m[i]) for (int j = 0; j <= 16; j++) m[i + j] = m[i + j] ^ gp[16 - j];
    for (int k = 0; k < 16; k++) r[15 - k] = m[len + k];
    return r;
  endfunction

  // fault 1: hcount shows 2 instead of 1 on line 0; fault 2: hblnk forced on pixel (1,1)
  task automatic run_cycles(input logic [11:0] fill, input int fault, input int first,
                            input int last, input bit rst_on);
    for (int i = first; i < last; i++) begin
      int h;
      int v;
      h = i % HT;
      v = i / HT;
      rst = rst_on;
      vif.hcount = 11'(h);
      vif.vcount = 11'(v);
      vif.hblnk  = (h >= HA);
      vif.vblnk  = (v >= VA);
      vif.hsync  = (h == HA + 1);
      vif.vsync  = (v == VA + 1);
      vif.rgb    = (h < HA && v < VA) ? fill : ~fill;
      if (fault == 1 && h == 1 && v == 0) vif.hcount = 11'd2;
      if (fault == 2 && h == 1 && v == 1) vif.hblnk = 1'b1;
      if (!vif.hblnk && !vif.vblnk) frame_pix.push_back(vif.rgb);
      if (v == VA + 1 && h == 0) vs_cyc = cyc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input logic [11:0] fill, input int fault, input bit expect_report);
    frame_pix.delete();
    mon_pulses = 0;
    run_cycles(fill, fault, 0, FRAME, 1'b0);
    if (expect_report) exp_q.push_back(model_crc(frame_pix));
  endtask

  task automatic test_reset();
    run_cycles(12'h000, 0, 0, 3, 1'b1);
    n_checks += 6;
    if (signature !== 16'h0000) begin n_errors++; $display("FAIL reset_signature: got %h want 0000", signature); end
    if (sig_valid !== 1'b0) begin n_errors++; $display("FAIL reset_sig_valid: got %b want 0", sig_valid); end
    if (frame_cnt !== 16'h0000) begin n_errors++; $display("FAIL reset_frame_cnt: got %h want 0000", frame_cnt); end
    if (locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    if (timing_err !== 1'b0) begin n_errors++; $display("FAIL reset_timing_err: got %b want 0", timing_err); end
    if (state !== SEEK) begin n_errors++; $display("FAIL reset_state: got %0d want SEEK", state); end
  endtask

  task automatic test_golden();
    logic [15:0] exp_sig;
    logic [15:0] first_sig;
    run_frame(12'h000, 0, 1'b0);
    n_checks += 4;
    if (mon_pulses !== 0) begin n_errors++; $display("FAIL golden_no_early_valid: got %0d pulses want 0", mon_pulses); end
    if (locked !== 1'b1) begin n_errors++; $display("FAIL golden_locked: got %b want 1", locked); end
    if (frame_cnt !== 16'd0) begin n_errors++; $display("FAIL golden_cnt0: got %0d want 0", frame_cnt); end
    if (state !== ACCUM) begin n_errors++; $display("FAIL golden_state: got %0d want ACCUM", state); end

    run_frame(12'h000, 0, 1'b1);
    exp_sig = exp_q.pop_front();
    first_sig = mon_sig;
    n_checks += 5;
    if (mon_pulses !== 1) begin n_errors++; $display("FAIL golden1_pulses: got %0d want 1", mon_pulses); end
    if (mon_sig !== exp_sig) begin n_errors++; $display("FAIL golden1_sig: got %h want %h", mon_sig, exp_sig); end
    if (mon_cnt !== 16'd1) begin n_errors++; $display("FAIL golden1_cnt: got %0d want 1", mon_cnt); end
    if (mon_err !== 1'b0) begin n_errors++; $display("FAIL golden1_err: got %b want 0", mon_err); end
    if (mon_cyc - vs_cyc !== 2) begin n_errors++; $display("FAIL golden1_latency: got %0d want 2", mon_cyc - vs_cyc); end

    run_frame(12'h000, 0, 1'b1);
    exp_sig = exp_q.pop_front();
    n_checks += 4;
    if (mon_sig !== exp_sig) begin n_errors++; $display("FAIL golden2_sig: got %h want %h", mon_sig, exp_sig); end
    if (mon_sig !== first_sig) begin n_errors++; $display("FAIL golden2_repeat: got %h want %h", mon_sig, first_sig); end
    if (mon_cnt !== 16'd2) begin n_errors++; $display("FAIL golden2_cnt: got %0d want 2", mon_cnt); end
    if (mon_err !== 1'b0) begin n_errors++; $display("FAIL golden2_err: got %b want 0", mon_err); end
  endtask

  task automatic test_fill();
    logic [15:0] sig_abc;
    logic [15:0] exp_sig;
    run_frame(12'hABC, 0, 1'b1);
    exp_sig = exp_q.pop_front();
    sig_abc = mon_sig;
    n_checks += 2;
    if (mon_sig !== exp_sig) begin n_errors++; $display("FAIL fill_abc_sig: got %h want %h", mon_sig, exp_sig); end
    if (mon_cnt !== 16'd3) begin n_errors++; $display("FAIL fill_abc_cnt: got %0d want 3", mon_cnt); end
    run_frame(12'hABD, 0, 1'b1);
    exp_sig = exp_q.pop_front();
    n_checks += 3;
    if (mon_sig !== exp_sig) begin n_errors++; $display("FAIL fill_abd_sig: got %h want %h", mon_sig, exp_sig); end
    if (mon_sig === sig_abc) begin n_errors++; $display("FAIL fill_differ: got %h want value other than %h", mon_sig, sig_abc); end
    if (mon_err !== 1'b0) begin n_errors++; $display("FAIL fill_abd_err: got %b want 0", mon_err); end
  endtask

  task automatic test_hskip();
    logic [15:0] exp_sig;
    run_frame(12'h3C5, 1, 1'b1);
    exp_sig = exp_q.pop_front();
    n_checks += 3;
    if (mon_err !== 1'b1) begin n_errors++; $display("FAIL hskip_err: got %b want 1", mon_err); end
    if (mon_sig !== exp_sig) begin n_errors++; $display("FAIL hskip_sig: got %h want %h", mon_sig, exp_sig); end
    if (mon_cnt !== 16'd5) begin n_errors++; $display("FAIL hskip_cnt: got %0d want 5", mon_cnt); end
    run_frame(12'h3C5, 0, 1'b1);
    void'(exp_q.pop_front());
    n_checks += 1;
    if (mon_err !== STICKY) begin n_errors++; $display("FAIL hskip_after_err: got %b want %b", mon_err, STICKY); end
  endtask

  task automatic test_hblnk();
    logic [15:0] exp_sig;
    run_frame(12'h5A5, 2, 1'b1);
    exp_sig = exp_q.pop_front();
    n_checks += 2;
    if (mon_err !== 1'b1) begin n_errors++; $display("FAIL hblnk_err: got %b want 1", mon_err); end
    if (mon_sig !== exp_sig) begin n_errors++; $display("FAIL hblnk_sig: got %h want %h", mon_sig, exp_sig); end
    run_frame(12'h5A5, 0, 1'b1);
    exp_sig = exp_q.pop_front();
    n_checks += 2;
    if (mon_err !== STICKY) begin n_errors++; $display("FAIL hblnk_after_err: got %b want %b", mon_err, STICKY); end
    if (mon_sig !== exp_sig) begin n_errors++; $display("FAIL hblnk_after_sig: got %h want %h", mon_sig, exp_sig); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] exp_sig;
    frame_pix.delete();
    mon_pulses = 0;
    run_cycles(12'h777, 0, 0, 8, 1'b0);
    run_cycles(12'h777, 0, 8, 10, 1'b1);
    n_checks += 6;
    if (signature !== 16'h0000) begin n_errors++; $display("FAIL midrst_signature: got %h want 0000", signature); end
    if (sig_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_sig_valid: got %b want 0", sig_valid); end
    if (frame_cnt !== 16'h0000) begin n_errors++; $display("FAIL midrst_frame_cnt: got %h want 0000", frame_cnt); end
    if (locked !== 1'b0) begin n_errors++; $display("FAIL midrst_locked: got %b want 0", locked); end
    if (timing_err !== 1'b0) begin n_errors++; $display("FAIL midrst_timing_err: got %b want 0", timing_err); end
    if (state !== SEEK) begin n_errors++; $display("FAIL midrst_state: got %0d want SEEK", state); end
    run_cycles(12'h777, 0, 10, FRAME, 1'b0);
    n_checks += 2;
    if (mon_pulses !== 0) begin n_errors++; $display("FAIL midrst_no_valid: got %0d pulses want 0", mon_pulses); end
    if (locked !== 1'b1) begin n_errors++; $display("FAIL midrst_relock: got %b want 1", locked); end
    run_frame(12'h123, 0, 1'b1);
    exp_sig = exp_q.pop_front();
    n_checks += 3;
    if (mon_cnt !== 16'd1) begin n_errors++; $display("FAIL midrst_cnt: got %0d want 1", mon_cnt); end
    if (mon_sig !== exp_sig) begin n_errors++; $display("FAIL midrst_sig: got %h want %h", mon_sig, exp_sig); end
    if (mon_err !== 1'b0) begin n_errors++; $display("FAIL midrst_err: got %b want 0", mon_err); end
  endtask

  task automatic test_latency();
    logic [15:0] exp_sig;
    run_frame(12'hF0F, 0, 1'b1);
    exp_sig = exp_q.pop_front();
    n_checks += 3;
    if (mon_pulses !== 1) begin n_errors++; $display("FAIL latency_pulses: got %0d want 1", mon_pulses); end
    if (mon_cyc - vs_cyc !== 2) begin n_errors++; $display("FAIL latency_cycles: got %0d want 2", mon_cyc - vs_cyc); end
    if (mon_sig !== exp_sig) begin n_errors++; $display("FAIL latency_sig: got %h want %h", mon_sig, exp_sig); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_fill();
    test_hskip();
    test_hblnk();
    test_reset_mid_frame();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
